// File: rtl/gray_step_monitor_if.sv
// Gray step monitor bus: sample input, clear control and monitor results.
// The master side drives samples and clr; the slave side is the monitor.
interface gray_step_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             clr;
  logic [WIDTH-1:0] gray_in;
  logic             gray_valid;
  logic [WIDTH-1:0] bin_out;
  logic             step_up;
  logic             step_down;
  logic             err_pulse;
  logic [CNT_W-1:0] pos_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output clr, gray_in, gray_valid,
    input  bin_out, step_up, step_down, err_pulse, pos_count, err_count
  );

  modport slave (
    input  clr, gray_in, gray_valid,
    output bin_out, step_up, step_down, err_pulse, pos_count, err_count
  );
endinterface

// File: rtl/gray_step_monitor.sv
// Gray step monitor: decodes Gray samples, classifies each accepted sample as
// a +1 step, a -1 step or an illegal jump relative to the last reference, and
// keeps a wrapping position counter and a saturating error counter.
// Optional feature macro: GRAY_MON_ERRCNT_EN includes the error counter;
// without it err_count is tied to zero (err_pulse and ERROR still work).
module gray_step_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  gray_step_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1'b1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1'b1);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t           state_r,     state_nxt_s;
  logic [WIDTH-1:0] ref_r,       ref_nxt_s;
  logic [WIDTH-1:0] bin_r,       bin_nxt_s;
  logic [CNT_W-1:0] pos_r,       pos_nxt_s;
  logic             step_up_r,   step_up_nxt_s;
  logic             step_down_r, step_down_nxt_s;
  logic             err_pulse_r, err_pulse_nxt_s;
  logic [WIDTH-1:0] dec_s;

  assign dec_s = gray2bin(bus.gray_in);

  // Next-state and next-output decision; clr outranks any same-cycle sample.
  always_comb begin
    state_nxt_s     = state_r;
    ref_nxt_s       = ref_r;
    bin_nxt_s       = bin_r;
    pos_nxt_s       = pos_r;
    step_up_nxt_s   = 1'b0;
    step_down_nxt_s = 1'b0;
    err_pulse_nxt_s = 1'b0;
    if (bus.clr) begin
      state_nxt_s = IDLE;
      pos_nxt_s   = '0;
    end else if (bus.gray_valid) begin
      case (state_r)
        IDLE, ERROR: begin
          // No trustworthy reference: take this sample as the new one.
          ref_nxt_s   = dec_s;
          bin_nxt_s   = dec_s;
          state_nxt_s = TRACK;
        end
        TRACK: begin
          if (dec_s == ref_r) begin
            state_nxt_s = TRACK;
          end else if (dec_s == ref_r + ONE_W) begin
            step_up_nxt_s = 1'b1;
            pos_nxt_s     = pos_r + ONE_C;
            ref_nxt_s     = dec_s;
            bin_nxt_s     = dec_s;
          end else if (dec_s == ref_r - ONE_W) begin
            step_down_nxt_s = 1'b1;
            pos_nxt_s       = pos_r - ONE_C;
            ref_nxt_s       = dec_s;
            bin_nxt_s       = dec_s;
          end else begin
            // Multi-bit jump: reference is no longer meaningful.
            err_pulse_nxt_s = 1'b1;
            bin_nxt_s       = dec_s;
            state_nxt_s     = ERROR;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, reference and registered outputs; rst outranks everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ref_r       <= '0;
      bin_r       <= '0;
      pos_r       <= '0;
      step_up_r   <= 1'b0;
      step_down_r <= 1'b0;
      err_pulse_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ref_r       <= ref_nxt_s;
      bin_r       <= bin_nxt_s;
      pos_r       <= pos_nxt_s;
      step_up_r   <= step_up_nxt_s;
      step_down_r <= step_down_nxt_s;
      err_pulse_r <= err_pulse_nxt_s;
    end
  end

`ifdef GRAY_MON_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_r;

  // Saturating illegal-transition counter, cleared by rst or clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= '0;
    end else if (bus.clr) begin
      err_cnt_r <= '0;
    end else if (err_pulse_nxt_s && (err_cnt_r != '1)) begin
      err_cnt_r <= err_cnt_r + ONE_C;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.err_count = err_cnt_r;
`else
  assign bus.err_count = '0;
`endif

  assign bus.bin_out   = bin_r;
  assign bus.step_up   = step_up_r;
  assign bus.step_down = step_down_r;
  assign bus.err_pulse = err_pulse_r;
  assign bus.pos_count = pos_r;

endmodule
